fetch_controller: RTL

Sequencing controller for the instruction memory in the RISC-V datapath. It owns the program counter, drives the word address into the combinational instruction memory, and buffers fetched instructions with their PCs in a small queue. The decode stage consumes from that queue through a valid/ready handshake. It also accepts PC redirects from branch/jump resolution, which flush the queue, and stall requests from the pipeline.

---
 rtl/fetch_controller.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, addresses the instruction memory and queues {instr, pc} for decode.
// Optional feature macro: FETCH_HALT_ON_ZERO_EN (halt fetch on an all-zero instruction word).
module fetch_controller #(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic [63:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instr_o,
  output logic [63:0] instr_pc_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [63:0] fetch_pc_o,
  output logic        halted_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [63:0]        pc_q, pc_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  fetch_entry_t       fifo_q [FIFO_DEPTH];

  logic pop_c;
  logic can_fetch_c;
  logic halt_hit_c;
  logic push_c;

  // Handshake and fetch qualification; a pop frees a slot in the same cycle.
  always_comb begin
    pop_c       = (count_q != '0) & instr_ready_i;
    can_fetch_c = (state_q == RUN) & ~stall_i & ~redirect_i &
                  ((count_q < DEPTH_C) | pop_c);
`ifdef FETCH_HALT_ON_ZERO_EN
    halt_hit_c  = can_fetch_c & (imem_data_i == 32'h0);
`else
    halt_hit_c  = 1'b0;
`endif
    push_c      = can_fetch_c & ~halt_hit_c;
  end

  // Control FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = RUN;
      end
      RUN: begin
        if (halt_hit_c) state_d = HALTED;
      end
      HALTED: begin
        if (redirect_i) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // PC and queue pointer updates; redirect flushes and overrides everything else.
  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect_i) begin
      pc_d    = redirect_pc_i & ~64'h3;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_c) begin
        pc_d   = pc_q + 64'd4;
        tail_d = tail_q + PTR_W'(1);
      end
      if (pop_c) begin
        head_d = head_q + PTR_W'(1);
      end
      unique case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Queue storage; a flushing redirect suppresses the push so no write happens that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push_c) begin
      fifo_q[tail_q] <= '{instr: imem_data_i, pc: pc_q};
    end
  end

  assign imem_addr_o   = {2'b00, pc_q[63:2]};
  assign fetch_pc_o    = pc_q;
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = instr_valid_o ? fifo_q[head_q].instr : 32'h0;
  assign instr_pc_o    = instr_valid_o ? fifo_q[head_q].pc    : 64'h0;

`ifdef FETCH_HALT_ON_ZERO_EN
  assign halted_o = (state_q == HALTED);
`else
  assign halted_o = 1'b0;
`endif

endmodule
